lsu_ctrl: RTL and testbench

Load/store controller between the pipeline MEM stage and `data_mem_unit`. It accepts one memory request per handshake, decodes RISC-V `funct3` into `bit_width`/`sign_extend`, and range-checks the address. It drives the memory port and holds it stable for the BRAM read latency. It returns loaded data or a store acknowledge, with a fault code, over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_if.sv | 42 ++++
 rtl/lsu_decode.sv | 62 ++++++
 rtl/lsu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store controller: FSM state encoding,
// response fault codes, memory access widths, RISC-V load/store funct3
// encodings and a small alignment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package lsu_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_t;

    // Fault code carried on the response channel
    typedef logic [1:0] lsu_fault_t;

    localparam lsu_fault_t FAULT_NONE     = 2'b00;
    localparam lsu_fault_t FAULT_ACCESS   = 2'b01;
    localparam lsu_fault_t FAULT_MISALIGN = 2'b10;
    localparam lsu_fault_t FAULT_ILLEGAL  = 2'b11;

    // Access width code understood by data_mem_unit
    localparam logic [1:0] BW_BYTE   = 2'b00;
    localparam logic [1:0] BW_HALF   = 2'b01;
    localparam logic [1:0] BW_WORD   = 2'b10;
    localparam logic [1:0] BW_DOUBLE = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // True when the low address bits are a multiple of the access size
    function automatic logic isAligned(input logic [1:0] bitWidth,
                                       input logic [2:0] addrLow);
        logic aligned;
        aligned = 1'b1;
        case (bitWidth)
            BW_HALF:   aligned = (addrLow[0] == 1'b0);
            BW_WORD:   aligned = (addrLow[1:0] == 2'b00);
            BW_DOUBLE: aligned = (addrLow[2:0] == 3'b000);
            default:   aligned = 1'b1;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Request/response handshake bundle between the pipeline MEM stage and
// lsu_ctrl.
//   master : pipeline side - drives request fields and resp_ready
//   slave  : lsu_ctrl side - drives req_ready and response fields
// Signals:
//   req_valid/req_ready   request handshake
//   req_store             1 = store, 0 = load
//   req_funct3            RISC-V funct3
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data (0 for stores and faults)
//   resp_fault            fault code
// ---------------------------------------------------------------------------
interface lsu_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    lsu_fault_t  resp_fault;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/lsu_decode.sv
// ---------------------------------------------------------------------------
// lsu_decode
// Purely combinational request decoder. Turns funct3, the store flag and the
// byte address into the memory width code, the sign-extend flag and the
// prioritised fault code (illegal > access > misaligned).
// Configuration macro: LSU_MISALIGN_TRAP_EN - when defined, an address that
// is not a multiple of the access size reports FAULT_MISALIGN.
// Ports:
//   i_store        1 = store, 0 = load
//   i_funct3       RISC-V funct3
//   i_addr         byte address
//   o_bit_width    00 B, 01 H, 10 W, 11 D
//   o_sign_extend  sign-extend loaded data
//   o_fault        fault code for this request
// ---------------------------------------------------------------------------
module lsu_decode #(
    parameter int DATA_MEM_LEN = 12
) (
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_addr,
    output logic [1:0]  o_bit_width,
    output logic        o_sign_extend,
    output logic [1:0]  o_fault
);
    import lsu_pkg::*;

    logic w_illegal;
    logic w_accessFault;
    logic w_misalign;
    logic w_unusedAddrBits;

    assign o_bit_width   = i_funct3[1:0];
    assign o_sign_extend = ~i_funct3[2];

    // Stores have no unsigned variants; 111 is not a defined load
    assign w_illegal = i_store ? i_funct3[2] : (i_funct3 == 3'b111);

    // Anything above the last byte of the memory is out of range
    assign w_accessFault = |i_addr[63:DATA_MEM_LEN+3];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ~isAligned(i_funct3[1:0], i_addr[2:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // In-range address bits only matter to the alignment check
    assign w_unusedAddrBits = ^i_addr[DATA_MEM_LEN+2:0];

    always_comb begin
        o_fault = FAULT_NONE;
        if (w_illegal) begin
            o_fault = FAULT_ILLEGAL;
        end else if (w_accessFault) begin
            o_fault = FAULT_ACCESS;
        end else if (w_misalign) begin
            o_fault = FAULT_MISALIGN;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store controller between the MEM stage and data_mem_unit. Accepts one
// request per handshake, drives the memory port steadily for the whole BRAM
// read latency, and returns load data or a store acknowledge together with a
// fault code. Faulting requests skip the memory entirely.
// Configuration macro: LSU_MISALIGN_TRAP_EN (see lsu_decode).
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   bus                  lsu_if.slave request/response handshake
//   o_mem_en, o_mem_wea  data_mem_unit en / wea
//   o_mem_addr, o_mem_din, o_mem_bit_width, o_mem_sign_extend
//                        data_mem_unit address, write data, width, extend
//   i_mem_dout           data_mem_unit dout
//   o_busy               controller not idle
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int DATA_MEM_LEN = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    lsu_if.slave        bus,
    output logic        o_mem_en,
    output logic        o_mem_wea,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_din,
    output logic [1:0]  o_mem_bit_width,
    output logic        o_mem_sign_extend,
    input  logic [63:0] i_mem_dout,
    output logic        o_busy
);
    import lsu_pkg::*;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    lsu_state_t r_state;
    lsu_state_t w_nextState;

    logic        r_store;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [1:0]  r_bitWidth;
    logic        r_signExt;
    lsu_fault_t  r_fault;
    logic [63:0] r_rdata;
    logic [2:0]  r_waitCnt;

    logic [1:0]  w_decBitWidth;
    logic        w_decSignExt;
    logic [1:0]  w_decFault;

    logic        w_accept;
    logic        w_capture;
    logic        w_memActive;
    logic        w_memWrite;
    logic        w_reqReady;
    logic        w_respValid;

    lsu_decode #(
        .DATA_MEM_LEN (DATA_MEM_LEN)
    ) u_decode (
        .i_store       (bus.req_store),
        .i_funct3      (bus.req_funct3),
        .i_addr        (bus.req_addr),
        .o_bit_width   (w_decBitWidth),
        .o_sign_extend (w_decSignExt),
        .o_fault       (w_decFault)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // req_ready and resp_valid depend on the state only; the incoming
    // req_valid merely selects where IDLE goes next.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_memActive = 1'b0;
        w_memWrite  = 1'b0;
        w_reqReady  = 1'b0;
        w_respValid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_reqReady = 1'b1;
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = (w_decFault == FAULT_NONE) ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                w_memActive = 1'b1;
                w_memWrite  = r_store;
                w_nextState = r_store ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                w_memActive = 1'b1;
                if (r_waitCnt == 3'd1) begin
                    w_capture   = 1'b1;
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                w_respValid = 1'b1;
                if (bus.resp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Request capture, latency counter and load-data capture. The read data
    // is cleared on acceptance so stores and faults answer with zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_store    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_bitWidth <= BW_BYTE;
            r_signExt  <= 1'b0;
            r_fault    <= FAULT_NONE;
            r_rdata    <= '0;
            r_waitCnt  <= '0;
        end else begin
            if (w_accept) begin
                r_store    <= bus.req_store;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_bitWidth <= w_decBitWidth;
                r_signExt  <= w_decSignExt;
                r_fault    <= w_decFault;
                r_rdata    <= '0;
            end
            if (r_state == S_ACCESS) begin
                r_waitCnt <= LAT;
            end else if (r_state == S_WAIT) begin
                r_waitCnt <= r_waitCnt - 3'd1;
            end
            if (w_capture) begin
                r_rdata <= i_mem_dout;
            end
        end
    end

    // data_mem_unit rotates dout from addr/width combinationally, so the
    // port is held at the registered request for all of ACCESS and WAIT and
    // parked at zero otherwise.
    assign o_mem_en          = w_memActive;
    assign o_mem_wea         = w_memWrite;
    assign o_mem_addr        = w_memActive ? r_addr : 64'd0;
    assign o_mem_din         = w_memActive ? r_wdata : 64'd0;
    assign o_mem_bit_width   = w_memActive ? r_bitWidth : BW_BYTE;
    assign o_mem_sign_extend = w_memActive & r_signExt;

    assign bus.req_ready  = w_reqReady;
    assign bus.resp_valid = w_respValid;
    assign bus.resp_rdata = w_respValid ? r_rdata : 64'd0;
    assign bus.resp_fault = w_respValid ? r_fault : FAULT_NONE;

    assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed and randomized load/store traffic against lsu_ctrl with a
// behavioural data_mem_unit and a byte-array reference of memory contents.
// Honours LSU_MISALIGN_TRAP_EN for expected fault codes.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int DML = 12;
    localparam int RL = 1;
    localparam int MEM_BYTES = 1 << (DML + 3);
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        memEn;
    logic        memWea;
    logic [63:0] memAddr;
    logic [63:0] memDin;
    logic [1:0]  memBitWidth;
    logic        memSignExtend;
    logic [63:0] memDout;
    logic        busy;

    int assertCount = 0;
    int failCount = 0;

    bit [7:0] dutMem [MEM_BYTES];
    bit [7:0] refMem [MEM_BYTES];
    int enRun = 0;

    lsu_if bus();

    always #5 clk = ~clk;

    lsu_ctrl #(
        .DATA_MEM_LEN (DML),
        .READ_LATENCY (RL)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rstN),
        .bus               (bus),
        .o_mem_en          (memEn),
        .o_mem_wea         (memWea),
        .o_mem_addr        (memAddr),
        .o_mem_din         (memDin),
        .o_mem_bit_width   (memBitWidth),
        .o_mem_sign_extend (memSignExtend),
        .i_mem_dout        (memDout),
        .o_busy            (busy)
    );

    // Memory-side read: assemble the bytes and extend by width
    function automatic logic [63:0] memRead(input logic [63:0] a, input logic [1:0] bw, input logic s);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (i < (1 << bw)) v[8*i +: 8] = dutMem[(int'(a[DML+2:0]) + i) % MEM_BYTES];
        case (bw)
            2'd0: if (s) v = {{56{v[7]}}, v[7:0]};
            2'd1: if (s) v = {{48{v[15]}}, v[15:0]};
            2'd2: if (s) v = {{32{v[31]}}, v[31:0]};
            default: ;
        endcase
        return v;
    endfunction

    // Behavioural data_mem_unit: data only valid once en has been held for
    // READ_LATENCY edges, otherwise a recognisable junk pattern.
    always @(posedge clk) begin
        if (memEn && memWea) begin
            for (int i = 0; i < 8; i++)
                if (i < (1 << memBitWidth))
                    dutMem[(int'(memAddr[DML+2:0]) + i) % MEM_BYTES] <= memDin[8*i +: 8];
        end
        if (memEn && !memWea) begin
            memDout <= (enRun + 1 >= RL) ? memRead(memAddr, memBitWidth, memSignExtend) : GARBAGE;
            enRun <= enRun + 1;
        end else begin
            memDout <= GARBAGE;
            enRun <= 0;
        end
    end

    function automatic logic [1:0] refFault(input logic st, input logic [2:0] f3, input logic [63:0] a);
        if (st ? f3[2] : (f3 == 3'b111)) return 2'b11;
        if (a >= 64'(MEM_BYTES)) return 2'b01;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % (64'd1 << f3[1:0])) != 0) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [63:0] refLoad(input logic [2:0] f3, input logic [63:0] a);
        int size;
        logic [63:0] val;
        logic [63:0] span;
        size = 1 << f3[1:0];
        val = 0;
        for (int i = 0; i < size; i++)
            val = val + (64'(refMem[int'((a + 64'(i)) % 64'(MEM_BYTES))]) << (8 * i));
        if (!f3[2] && size < 8) begin
            span = 64'd1 << (8 * size);
            if (val >= (span >> 1)) val = val - span;
        end
        return val;
    endfunction

    task automatic refStore(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++)
            refMem[int'((a + 64'(i)) % 64'(MEM_BYTES))] = 8'((wd >> (8 * i)) & 64'hFF);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full request/response transaction, with optional response stall
    task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wd, input int stall,
                                 output logic [63:0] gotData, output logic [1:0] gotFault);
        logic [1:0]  expFault;
        logic [63:0] expData;
        int expLat, expEn, expWea;
        int cyc, enCnt, weaCnt, portBad;
        bit seen;
        expFault = refFault(st, f3, addr);
        expData = 0;
        if (expFault != 2'b00) begin
            expLat = 1; expEn = 0; expWea = 0;
        end else if (st) begin
            expLat = 2; expEn = 1; expWea = 1;
            refStore(f3, addr, wd);
        end else begin
            expLat = 2 + RL; expEn = 1 + RL; expWea = 0;
            expData = refLoad(f3, addr);
        end

        @(negedge clk);
        checkOutput({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        cyc = 0; enCnt = 0; weaCnt = 0; portBad = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (memEn === 1'b1) begin
                enCnt++;
                if ({memAddr, memBitWidth, memSignExtend} !== {addr, f3[1:0], ~f3[2]}) portBad++;
            end
            if (memWea === 1'b1) begin
                weaCnt++;
                if (memDin !== wd) portBad++;
            end
            seen = (bus.resp_valid === 1'b1);
        end

        checkOutput({tag, " resp latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, " mem_en cycles"}, 64'(enCnt), 64'(expEn));
        checkOutput({tag, " mem_wea cycles"}, 64'(weaCnt), 64'(expWea));
        checkOutput({tag, " mem port hold"}, 64'(portBad), 64'd0);
        checkOutput({tag, " resp_fault"}, 64'(bus.resp_fault), 64'(expFault));
        checkOutput({tag, " resp_rdata"}, bus.resp_rdata, expData);
        checkOutput({tag, " req_ready/busy in resp"}, {62'd0, bus.req_ready, busy}, 64'd1);
        gotData = bus.resp_rdata;
        gotFault = bus.resp_fault;

        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checkOutput({tag, " stall hold"}, {bus.resp_valid, bus.req_ready, bus.resp_fault, bus.resp_rdata[59:0]},
                        {1'b1, 1'b0, expFault, expData[59:0]});
        end

        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  f;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] a;
        int          sel;

        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("reset flags", {56'd0, memEn, memWea, memBitWidth, memSignExtend, busy, bus.resp_valid, 1'b0}, 64'd0);
        checkOutput("reset resp_fault", 64'(bus.resp_fault), 64'd0);
        checkOutput("reset resp_rdata", bus.resp_rdata, 64'd0);
        checkOutput("reset mem_addr", memAddr, 64'd0);
        checkOutput("reset mem_din", memDin, 64'd0);
        rstN = 1'b1;

        // Doubleword round trip
        applyStimulus("SD 0x10", 1'b1, SD, 64'h10, 64'h1122334455667788, 0, d, f);
        applyStimulus("LD 0x10", 1'b0, LD, 64'h10, 64'h0, 0, d, f);
        checkOutput("LD 0x10 const data", d, 64'h1122334455667788);
        checkOutput("LD 0x10 const fault", 64'(f), 64'd0);

        // Byte sign/zero extension
        applyStimulus("SB 0x21", 1'b1, SB, 64'h21, 64'h80, 0, d, f);
        applyStimulus("LB 0x21", 1'b0, LB, 64'h21, 64'h0, 0, d, f);
        checkOutput("LB 0x21 const", d, 64'hFFFFFFFFFFFFFF80);
        applyStimulus("LBU 0x21", 1'b0, LBU, 64'h21, 64'h0, 0, d, f);
        checkOutput("LBU 0x21 const", d, 64'h0000000000000080);

        // Out-of-range and illegal encodings
        applyStimulus("LW 0x8000", 1'b0, LW, 64'h8000, 64'h0, 0, d, f);
        checkOutput("LW 0x8000 const fault", 64'(f), 64'd1);
        checkOutput("LW 0x8000 const data", d, 64'd0);
        applyStimulus("load f3=111", 1'b0, 3'b111, 64'h40, 64'h0, 0, d, f);
        checkOutput("load f3=111 const fault", 64'(f), 64'd3);
        applyStimulus("store f3=100", 1'b1, 3'b100, 64'h40, 64'h55, 0, d, f);
        checkOutput("store f3=100 const fault", 64'(f), 64'd3);

        // Misaligned doubleword across a row boundary
        applyStimulus("SD 0x5", 1'b1, SD, 64'h5, 64'hA1B2C3D4E5F60718, 0, d, f);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("SD 0x5 const fault", 64'(f), 64'd2);
`else
        checkOutput("SD 0x5 const fault", 64'(f), 64'd0);
`endif
        applyStimulus("LD 0x5", 1'b0, LD, 64'h5, 64'h0, 0, d, f);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("LD 0x5 const fault", 64'(f), 64'd2);
`else
        checkOutput("LD 0x5 const data", d, 64'hA1B2C3D4E5F60718);
`endif

        // Response held for 5 cycles
        applyStimulus("LD stall", 1'b0, LD, 64'h10, 64'h0, 5, d, f);

        // Reset during WAIT drops the response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_store = 1'b0;
        bus.req_funct3 = LD;
        bus.req_addr = 64'h10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset WAIT en/wea", {62'd0, memEn, memWea}, 64'd2);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset idle", {60'd0, bus.resp_valid, busy, memEn, bus.req_ready}, 64'd1);
        rstN = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 48; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0) a = {32'($urandom), 32'($urandom)} | 64'h8000;
            else if (sel == 1) a = 64'(MEM_BYTES - 8 + $urandom_range(0, 7));
            else a = 64'($urandom_range(0, 63));
            applyStimulus($sformatf("rand%0d", n), st, f3, a, {32'($urandom), 32'($urandom)},
                          $urandom_range(0, 3), d, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
